// File: rtl/stack_ret.sv
// Return-address stack (LIFO) for the single-cycle CPU.
// Push stores PC+1 on a call. On a return the top entry is presented
// combinationally so the PC mux can load it in the same cycle, and the pop
// takes effect at the next rising edge. The block also reports occupancy and
// holds sticky overflow/underflow flags that clear only on reset.
module stack_ret #(
  parameter int AW  = 10,
  parameter int SPW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] d_in,
  output logic [AW-1:0] d_out,
  output logic [SPW:0]  count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int           DEPTH   = 2 ** SPW;
  localparam logic [SPW:0] SP_FULL = (SPW + 1)'(DEPTH);
  localparam logic [SPW:0] SP_ONE  = (SPW + 1)'(1);

  // Storage is deliberately left unreset: d_out is forced to 0 while empty,
  // so stale contents are never visible.
  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW:0]   sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           sp_empty, sp_full;
  logic [SPW:0]   sp_m1;
  logic [SPW-1:0] top_idx;
  logic           wr_en;
  logic [SPW-1:0] wr_idx;

  assign sp_empty = (sp_q == '0);
  assign sp_full  = (sp_q == SP_FULL);
  assign sp_m1    = sp_q - SP_ONE;
  assign top_idx  = sp_m1[SPW-1:0];

  // Next-state for pointer, sticky flags and the array write port.
  always_comb begin
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[SPW-1:0];
    unique case ({push, pop})
      2'b10: begin
        if (sp_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = sp_q[SPW-1:0];
          sp_d   = sp_q + SP_ONE;
        end
      end
      2'b01: begin
        if (sp_empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d = sp_m1;
        end
      end
      2'b11: begin
        // Replace the top entry; on an empty stack this degenerates to a push
        // into slot 0, and neither error flag is touched.
        wr_en = 1'b1;
        if (sp_empty) begin
          wr_idx = '0;
          sp_d   = SP_ONE;
        end else begin
          wr_idx = top_idx;
        end
      end
      default: begin
        sp_d = sp_q;
      end
    endcase
  end

  // Pointer and sticky flags, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return-address array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= d_in;
    end
  end

  // Top-of-stack read, purely from registered state.
  always_comb begin
    d_out = '0;
    if (!sp_empty) begin
      d_out = mem_q[top_idx];
    end
  end

  assign count = sp_q;
  assign empty = sp_empty;
  assign full  = sp_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_ret.sv
// Scoreboard bench for stack_ret: the driver advances a queue-based LIFO
// model on every edge and enqueues the expected outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_stack_ret;

  localparam int AW  = 10;
  localparam int SPW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop;
  logic [AW-1:0] d_in;
  logic [AW-1:0] d_out;
  logic [SPW:0]  count;
  logic          empty, full, ovf, unf;

  stack_ret #(.AW(AW), .SPW(SPW)) dut (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .d_in (d_in),
    .d_out(d_out),
    .count(count),
    .empty(empty),
    .full (full),
    .ovf  (ovf),
    .unf  (unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SPW:0]  cnt;
    logic [AW-1:0] dout;
    logic          emp;
    logic          ful;
    logic          ov;
    logic          un;
  } exp_t;

  exp_t sb[$];
  int   model[$];
  bit   m_ovf, m_unf;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.cnt  = (SPW + 1)'(model.size());
    e.dout = (model.size() == 0) ? '0 : AW'(model[model.size() - 1]);
    e.emp  = (model.size() == 0);
    e.ful  = (model.size() == DEPTH);
    e.ov   = m_ovf;
    e.un   = m_unf;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".count"}, 16'(count), 16'(e.cnt));
    chk({tag, ".d_out"}, 16'(d_out), 16'(e.dout));
    chk({tag, ".empty"}, 16'(empty), 16'(e.emp));
    chk({tag, ".full"},  16'(full),  16'(e.ful));
    chk({tag, ".ovf"},   16'(ovf),   16'(e.ov));
    chk({tag, ".unf"},   16'(unf),   16'(e.un));
  endtask

  // Behavioural LIFO: one rising edge with the given request.
  task automatic model_edge(input bit ps, input bit pp, input logic [AW-1:0] d);
    if (ps && !pp) begin
      if (model.size() < DEPTH) model.push_back(int'(d));
      else m_ovf = 1'b1;
    end else if (pp && !ps) begin
      if (model.size() > 0) void'(model.pop_back());
      else m_unf = 1'b1;
    end else if (ps && pp) begin
      if (model.size() > 0) model[model.size() - 1] = int'(d);
      else model.push_back(int'(d));
    end
  endtask

  task automatic step(input bit ps, input bit pp, input logic [AW-1:0] d);
    push = ps;
    pop  = pp;
    d_in = d;
    @(posedge clk);
    model_edge(ps, pp, d);
    #1;
    sb.push_back(model_exp());
    push = 1'b0;
    pop  = 1'b0;
    d_in = '0;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge,
  // and an edge during reset must be ignored.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    model.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_outputs("async_rst", model_exp());
    push = 1'b1;
    d_in = 10'h3FF;
    @(posedge clk);
    #1;
    check_outputs("rst_hold", model_exp());
    push  = 1'b0;
    d_in  = '0;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_outputs("mon", e);
    end
  end

  initial begin
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    d_in  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_outputs("reset", model_exp());

    // LIFO order
    step(1, 0, 10'h005);
    step(1, 0, 10'h0A3);
    step(1, 0, 10'h3FF);
    repeat (3) step(0, 1, '0);

    // Simultaneous push+pop, non-empty and empty cases
    step(1, 0, 10'h005);
    step(1, 0, 10'h0A3);
    step(1, 1, 10'h155);
    step(0, 1, '0);
    step(0, 1, '0);
    step(1, 1, 10'h077);
    step(0, 1, '0);

    // Fill to full, overflow, then drain
    for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(10'h010 + i));
    step(1, 0, 10'h2AA);
    step(0, 1, '0);
    repeat (DEPTH - 1) step(0, 1, '0);

    // Underflow from empty, flag stays sticky
    step(0, 1, '0);
    step(1, 0, 10'h123);
    step(0, 1, '0);

    // Reset mid call sequence
    for (int i = 0; i < 5; i++) step(1, 0, AW'(10'h040 + i));
    async_reset();
    step(1, 0, 10'h001);

    // Randomized traffic with occasional bursts to reach both boundaries
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (i >= 100 && i < 130) step(1, 0, AW'($urandom));
      else if (i >= 200 && i < 230) step(0, 1, '0);
      else if (r < 40) step(1, 0, AW'($urandom));
      else if (r < 75) step(0, 1, '0);
      else if (r < 85) step(1, 1, AW'($urandom));
      else step(0, 0, AW'($urandom));
      if (i == 300) async_reset();
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_ret.md
Name: stack_ret

Overview:
- Return-address stack (LIFO) for the single-cycle CPU; it is the consumer of the push, pop and s_stack controls driven by the control unit.
- On a subroutine call, push stores the return address (PC+1 from the incrementer).
- On a return, the top entry is presented combinationally so the PC mux (s_stack=1) loads it in the same cycle. The pop takes effect at the next rising clock edge.
- Adds occupancy reporting and sticky overflow/underflow error flags.

Parameters:
- AW, 10, width of a stored return address (matches PC width).
- SPW, 4, stack-pointer width; depth = 2**SPW entries (16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- push  input  1  store d_in on top of stack at the next edge.
- pop  input  1  discard the top entry at the next edge.
- d_in  input  AW  return address to store (PC+1).
- d_out  output  AW  current top entry, combinational from state; 0 when empty.
- count  output  SPW+1  number of valid entries, 0..2**SPW.
- empty  output  1  count==0.
- full  output  1  count==2**SPW.
- ovf  output  1  sticky: push attempted while full.
- unf  output  1  sticky: pop attempted while empty.

Behaviour:
- Storage: 2**SPW x AW register array plus pointer register sp (SPW+1 bits, equal to count). The array is not reset. sp, ovf and unf reset asynchronously on reset falling, independent of clk.
- Reset values: count=0, empty=1, full=0, ovf=0, unf=0, d_out=0.
- While reset=0, all edges are ignored. A reset asserted mid-call sequence discards all entries; array contents are irrelevant because d_out is forced to 0 while empty.
- d_out = mem[sp-1] when sp!=0, else 0. It is purely combinational from registered state (no input-to-output path), with zero latency relative to sp.
- Per rising edge, with the flags computed from pre-edge state:
  - push=0, pop=0: hold.
  - push=1, pop=0, not full: mem[sp] <= d_in; sp <= sp+1.
  - push=1, pop=0, full: no change to mem or sp; ovf <= 1.
  - push=0, pop=1, not empty: sp <= sp-1. The popped entry is not cleared.
  - push=0, pop=1, empty: no change; unf <= 1.
  - push=1, pop=1, not empty: replace top, i.e. mem[sp-1] <= d_in; sp unchanged. Full does not matter here and no flag is set.
  - push=1, pop=1, empty: behaves as a plain push (mem[0] <= d_in, sp <= 1). unf is not set.
- ovf and unf stay set until reset. They are never cleared by normal operation.
- Wrap-around is forbidden: sp never exceeds 2**SPW and never goes below 0. The array index uses the low SPW bits of sp (or sp-1).
- After a push, d_out equals the pushed value in the following cycle. After a pop, d_out shows the previous entry in the following cycle.
- The control unit asserts push and pop mutually exclusively. The simultaneous case is still fully defined for robustness and for use by future call-return instructions.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> count=0, empty=1, d_out=0, ovf=unf=0. Assert reset=0 between edges -> outputs reset immediately (asynchronous).
- LIFO order: push 0x005, 0x0A3, 0x3FF on 3 consecutive edges -> count=3, d_out=0x3FF. Three pops -> d_out sequence 0x0A3, 0x005, 0, with empty=1 after the third pop.
- Full/overflow: push 16 values 0x010..0x01F -> full=1, d_out=0x01F. A 17th push of 0x2AA -> count stays 16, d_out=0x01F, ovf=1. A subsequent pop -> d_out=0x01E, ovf still 1.
- Underflow: from empty, pop -> count=0, d_out=0, unf=1. Then push 0x123 -> d_out=0x123, unf still 1.
- Simultaneous push+pop: with stack holding 0x005, 0x0A3, drive push=pop=1, d_in=0x155 -> count=2, d_out=0x155; one pop -> d_out=0x005. From empty, push=pop=1, d_in=0x077 -> count=1, d_out=0x077, unf=0.
- Reset mid-operation: push 5 entries, assert reset=0 for 1 cycle -> count=0, d_out=0, flags 0. Then push 0x001 -> d_out=0x001, count=1.
